// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time and
// buffers returned words in a DEPTH-entry prefetch queue feeding decode.
// Optional build macro FETCH_PERF_EN adds the starve_cnt performance counter.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] starve_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard, StHalted} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     req_addr_q, req_addr_d;
  logic            halt_pend_q, halt_pend_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [15:0]     instr_mem [DEPTH];
  logic [15:0]     pc_mem    [DEPTH];

  logic push, pop, slot_free, hlt_seen;

  // A redirect flushes the queue, so a pop in that cycle is meaningless.
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & id_ready & ~redirect;
  // Only one request is ever in flight, so a free slot at issue stays free until its ack.
  assign slot_free   = (count_q < DepthCnt) | pop;
  // Halt seen at any point while a request is in flight takes effect once it completes.
  assign hlt_seen    = hlt | halt_pend_q;

  assign instr    = instr_valid ? instr_mem[rd_ptr_q] : 16'h0000;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr_q]    : 16'h0000;

  // Next-state, fetch address and memory request decode.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        if (hlt) begin
          state_d = StHalted;
        end else if (!redirect && slot_free) begin
          state_d    = StWait;
          req_addr_d = fetch_pc_q;
        end
      end
      StWait: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) begin
          push = ~redirect;
          if (!redirect) begin
            fetch_pc_d = req_addr_q + 16'd1;
          end
          state_d = hlt_seen ? StHalted : StIdle;
        end else if (redirect) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        // Old address held until memory answers; that answer is thrown away.
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) begin
          state_d = hlt_seen ? StHalted : StIdle;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end
    halt_pend_d = ((state_d == StWait) || (state_d == StDiscard)) & hlt_seen;
  end

  // Control state and queue pointers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      halt_pend_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      halt_pend_q <= halt_pend_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  // Queue storage; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_addr_q + 16'd1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] starve_q;

  // Cycles where decode wanted an instruction but the queue was empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 16'h0000;
    end else if (id_ready && !instr_valid && !hlt && (starve_q != 16'hFFFF)) begin
      starve_q <= starve_q + 16'd1;
    end
  end

  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected queue outputs.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [15:0] w_pc;

`ifdef FETCH_PERF_EN
  logic [15:0] starve_cnt;
  logic [15:0] w_starve;
`endif

  int          passed;
  int          total;
  logic [31:0] exp_q[$];
  logic [15:0] ack_log[$];
  int          lat;
  logic        mem_en;
  logic        mon_en;

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .id_ready   (id_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .hlt        (hlt)
`ifdef FETCH_PERF_EN
    ,
    .starve_cnt (starve_cnt)
`endif
  );

  // Second instance only to observe a non-zero reset address.
  fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_ack   (1'b0),
    .imem_rdata (16'h0000),
    .instr_valid(w_valid),
    .instr      (w_instr),
    .instr_pc   (w_pc),
    .id_ready   (1'b0),
    .redirect   (1'b0),
    .redirect_pc(16'h0000),
    .hlt        (1'b0)
`ifdef FETCH_PERF_EN
    ,
    .starve_cnt (w_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a);
    logic [15:0] d;
    logic [15:0] p;
    d = a ^ 16'hA5A5;
    p = a + 16'd1;
    exp_q.push_back({d, p});
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en      = 1'b0;
    rst         = 1'b1;
    hlt         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    id_ready    = 1'b0;
    mem_en      = 1'b1;
    lat         = 1;
    step(2);
    exp_q.delete();
    ack_log.delete();
  endtask

  // Memory model: answers a held request after lat cycles with rdata = addr ^ A5A5.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst || !mem_en || !imem_req) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ 16'hA5A5;
        ack_log.push_back(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Scoreboard: every pop by decode must match the oldest expected entry.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && instr_valid && id_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {instr, instr_pc}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_instr", 32'(instr), 32'(e[31:16]));
          chk("pop_pc", 32'(instr_pc), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int req_seen;
    passed = 0;
    total  = 0;
    mem_en = 1'b1;
    mon_en = 1'b0;
    lat    = 1;

    // Reset state.
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0000);
    chk("rst_pc", 32'(instr_pc), 32'h0000);
    chk("rst_w_addr", 32'(w_addr), 32'hFFFE);
    chk("rst_w_req", 32'(w_req), 32'd0);

    // Streaming fetch with id_ready high.
    for (int a = 0; a < 6; a++) push_exp(16'(a));
    id_ready = 1'b1;
    rst      = 1'b0;
    mon_en   = 1'b1;
    step(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0000);
    chk("w_first_req", 32'(w_req), 32'd1);
    chk("w_first_addr", 32'(w_addr), 32'hFFFE);
    chk("w_empty", {w_valid, w_instr, w_pc[14:0]}, 32'h0);
    n = 0;
    while (!imem_ack && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ack_seen", 32'(imem_ack), 32'd1);
    chk("no_bypass", 32'(instr_valid), 32'd0);
    step(1);
    chk("valid_after_ack", 32'(instr_valid), 32'd1);
    chk("head_instr", 32'(instr), 32'hA5A5);
    chk("head_pc", 32'(instr_pc), 32'h0001);
    drain("stream_drain", 100);

    // Back-pressure: queue fills to DEPTH then fetching stops.
    do_reset();
    for (int a = 0; a < 6; a++) push_exp(16'(a));
    rst    = 1'b0;
    mon_en = 1'b1;
    step(30);
    chk("full_acks", ack_log.size(), 4);
    chk("full_no_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head", 32'(instr), 32'hA5A5);
    id_ready = 1'b1;
    drain("full_drain", 100);
    id_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("refill_valid", 32'(instr_valid), 32'd1);
    mon_en = 1'b0;
    rst    = 1'b1;
    step(1);
    chk("rst_flush_valid", 32'(instr_valid), 32'd0);
    chk("rst_flush_instr", 32'(instr), 32'h0000);
    chk("rst_flush_req", 32'(imem_req), 32'd0);
    chk("rst_flush_addr", 32'(imem_addr), 32'h0000);

    // Redirect while a request waits: stale data dropped.
    do_reset();
    for (int a = 'h40; a < 'h43; a++) push_exp(16'(a));
    lat      = 3;
    id_ready = 1'b1;
    rst      = 1'b0;
    mon_en   = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin
      step(1);
      n++;
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step(1);
    redirect = 1'b0;
    chk("discard_req", 32'(imem_req), 32'd1);
    chk("discard_addr", 32'(imem_addr), 32'h0000);
    drain("redirect_drain", 200);
    chk("redir_ack0", 32'(ack_log[0]), 32'h0000);
    chk("redir_ack1", 32'(ack_log[1]), 32'h0040);

    // Address wrap through FFFF.
    do_reset();
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    rst         = 1'b0;
    mon_en      = 1'b1;
    step(1);
    redirect = 1'b0;
    drain("wrap_drain", 100);
    chk("wrap_ack0", 32'(ack_log[0]), 32'hFFFE);
    chk("wrap_ack1", 32'(ack_log[1]), 32'hFFFF);
    chk("wrap_ack2", 32'(ack_log[2]), 32'h0000);

    // Redirect with a non-empty queue flushes it.
    do_reset();
    rst    = 1'b0;
    mon_en = 1'b1;
    n = 0;
    while (ack_log.size() < 2 && n < 30) begin
      step(1);
      n++;
    end
    chk("pre_flush_valid", 32'(instr_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    step(1);
    redirect = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    push_exp(16'h0080);
    push_exp(16'h0081);
    id_ready = 1'b1;
    drain("flush_drain", 100);

    // Halt during WAIT: pending word kept, no further requests.
    do_reset();
    push_exp(16'h0000);
    lat    = 2;
    rst    = 1'b0;
    mon_en = 1'b1;
    step(1);
    chk("halt_wait_req", 32'(imem_req), 32'd1);
    hlt      = 1'b1;
    req_seen = 0;
    step(4);
    for (int i = 0; i < 10; i++) begin
      if (imem_req) req_seen++;
      step(1);
    end
    chk("halt_no_req", req_seen, 0);
    chk("halt_acks", ack_log.size(), 1);
    chk("halt_valid", 32'(instr_valid), 32'd1);
    hlt = 1'b0;
    step(5);
    chk("halted_sticky", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    drain("halt_drain", 20);
    step(5);
    chk("halt_empty", 32'(instr_valid), 32'd0);
    chk("halt_still_idle", 32'(imem_req), 32'd0);

`ifdef FETCH_PERF_EN
    // Starvation counter with a silent memory.
    do_reset();
    mem_en   = 1'b0;
    id_ready = 1'b1;
    rst      = 1'b0;
    step(10);
    chk("starve_cnt", 32'(starve_cnt), 32'd10);
`endif

    do_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set prefetch queue entries (power of 2, 2..16).
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the first fetch address after reset.
REQ-003 Timing: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  16  word address of request.
REQ-008 imem_ack  input  1  memory returns data this cycle for the outstanding request.
REQ-009 imem_rdata  input  16  instruction word, valid with imem_ack.
REQ-010 instr_valid  output  1  queue head holds a valid instruction.
REQ-011 instr  output  16  queue head instruction word.
REQ-012 instr_pc  output  16  queue head fetch address plus 1 (mod 2^16).
REQ-013 id_ready  input  1  decode accepts head; pop when instr_valid & id_ready.
REQ-014 redirect  input  1  branch taken; flush and refetch.
REQ-015 redirect_pc  input  16  new fetch address, sampled with redirect.
REQ-016 hlt  input  1  halt; stop issuing new requests.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, DISCARD, HALTED.
REQ-018 At most one request SHALL be outstanding; imem_req and imem_addr SHALL hold stable in WAIT until imem_ack.
REQ-019 IDLE->WAIT SHALL occur when ~hlt & ~redirect & (count < DEPTH); imem_req asserts that same cycle (combinational from state), imem_addr = fetch_pc.
REQ-020 WAIT with imem_ack: push {imem_rdata, fetch_pc+1}, fetch_pc += 1 (wrap 16'hFFFF->16'h0000), go IDLE.
REQ-021 Push on ack SHALL never overflow: a request only issues when a slot is free, counting pops.
REQ-022 Pop and push in the same cycle SHALL leave count unchanged; ordering FIFO.
REQ-023 Empty queue: instr_valid=0, instr=16'h0000, instr_pc=16'h0000; no bypass, minimum memory-ack-to-instr_valid latency one cycle.
REQ-024 redirect SHALL empty the queue that cycle (pop ignored), load fetch_pc <= redirect_pc.
REQ-025 redirect in WAIT without imem_ack -> DISCARD; redirect coincident with imem_ack -> data dropped, go IDLE.
REQ-026 DISCARD SHALL hold imem_req=1 with old address until imem_ack, drop the data, then go IDLE.
REQ-027 hlt in IDLE -> HALTED; hlt in WAIT SHALL complete the request, then HALTED; HALTED issues nothing and queue still drains to decode.
REQ-028 HALTED SHALL be left only by rst; redirect in HALTED updates fetch_pc and flushes only.

Reset
REQ-029 On rst: state IDLE, fetch_pc=RESET_PC, queue empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-030 rst SHALL override all inputs including a coincident imem_ack, whose data is dropped; an outstanding request is abandoned.

Configuration
REQ-031 Macro FETCH_PERF_EN defined: output starve_cnt[15:0] SHALL count cycles with id_ready & ~instr_valid & ~hlt, saturating at 16'hFFFF, cleared by rst.
REQ-032 FETCH_PERF_EN undefined: port starve_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 rst, memory acks 1 cycle after req with rdata=addr^16'hA5A5, id_ready=1 -> instr 16'hA5A5,16'hA5A4,... instr_pc 1,2,3 in order.
REQ-034 id_ready=0 with DEPTH=4 -> exactly 4 acks accepted, imem_req stays 0 after; then id_ready=1 -> 4 pops in order, fetching resumes.
REQ-035 redirect_pc=16'h0040 while WAIT, ack 3 cycles later -> that data never appears; next request addr 16'h0040, first instr_pc 16'h0041.
REQ-036 RESET_PC=16'hFFFE -> imem_addr FFFE, FFFF, 0000; instr_pc FFFF, 0000, 0001.
REQ-037 hlt asserted in WAIT -> pending ack pushed, no further imem_req, queue drains, state HALTED until rst.
REQ-038 FETCH_PERF_EN defined, memory never acks, id_ready=1 for 10 cycles after rst -> starve_cnt=10.
